// File: rtl/sample_frame_pack_if.sv
// sample_frame_pack_if: per-channel sample stream from the network receive path.
// A sample transfers on a cycle where s_valid && s_ready.
interface sample_frame_pack_if #(
  parameter int SAMPLE_W = 32,
  parameter int CH_W     = 3
) ();
  logic                s_valid;
  logic                s_ready;
  logic [CH_W-1:0]     s_chan;
  logic [SAMPLE_W-1:0] s_data;
  logic                s_last;

  modport master (
    output s_valid,
    output s_chan,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_chan,
    input  s_data,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/sample_frame_pack.sv
// sample_frame_pack: gathers per-channel samples into an 8-channel frame and
// hands frames to the TDM serializer, at most one per frame_tick.
// Double-buffered: fbuf collects the frame being filled, rbuf holds the frame
// waiting for the next frame_tick.
// Optional build macro SAMPLE_HOLD_EN: unfilled channels repeat the value from
// the previously issued frame instead of being zeroed.
module sample_frame_pack #(
  parameter int SAMPLE_W = 32,
  parameter int NUM_CH   = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         enable,
  sample_frame_pack_if.slave           s,
  input  logic                         frame_tick,
  output logic                         valid,
  output logic [SAMPLE_W*NUM_CH-1:0]   pdata,
  output logic                         missIncr,
  output logic                         dupIncr,
  output logic                         underrunIncr
);

  localparam int FRAME_W = SAMPLE_W * NUM_CH;
  localparam logic [NUM_CH-1:0] MASK_FULL = {NUM_CH{1'b1}};
  localparam logic [NUM_CH-1:0] MASK_ONE  = {{(NUM_CH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [FRAME_W-1:0]  fbuf_r;
  logic [NUM_CH-1:0]   fmask_r;
  logic [FRAME_W-1:0]  rbuf_r;
  logic                rbufv_r;
  logic [NUM_CH-1:0]   chan_bit_s;
  logic [NUM_CH-1:0]   fmask_upd_s;
  logic [FRAME_W-1:0]  xfer_frame_s;
  logic                s_ready_s;
  logic                accept_s;
  logic                dup_s;
  logic                xfer_s;
  logic                miss_s;
  logic                issue_s;
  logic                underrun_s;

  // Per channel: take the filled sample, otherwise the fallback slot value.
  function automatic logic [FRAME_W-1:0] merge_frame(
    input logic [FRAME_W-1:0] frame,
    input logic [NUM_CH-1:0]  mask,
    input logic [FRAME_W-1:0] fallback
  );
    logic [FRAME_W-1:0] res;
    res = {FRAME_W{1'b0}};
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (mask[ch]) begin
        res[ch*SAMPLE_W +: SAMPLE_W] = frame[ch*SAMPLE_W +: SAMPLE_W];
      end else begin
        res[ch*SAMPLE_W +: SAMPLE_W] = fallback[ch*SAMPLE_W +: SAMPLE_W];
      end
    end
    return res;
  endfunction

  assign s.s_ready   = s_ready_s;
  assign chan_bit_s  = MASK_ONE << s.s_chan;
  assign fmask_upd_s = fmask_r | chan_bit_s;

  // Next-state and handshake/control strobes for the fill/pend machine.
  always_comb begin
    state_s    = state_r;
    s_ready_s  = 1'b0;
    accept_s   = 1'b0;
    dup_s      = 1'b0;
    xfer_s     = 1'b0;
    miss_s     = 1'b0;
    issue_s    = frame_tick & rbufv_r;
    underrun_s = frame_tick & ~rbufv_r;
    case (state_r)
      ST_FILL: begin
        s_ready_s = enable;
        accept_s  = enable & s.s_valid;
        if (accept_s) begin
          dup_s = fmask_r[s.s_chan];
          if (s.s_last || (fmask_upd_s == MASK_FULL)) begin
            state_s = ST_PEND;
          end else begin
            state_s = ST_FILL;
          end
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_PEND: begin
        // rbuf is free, or is being emptied by this tick: move the frame over.
        if (enable && (!rbufv_r || frame_tick)) begin
          xfer_s  = 1'b1;
          miss_s  = (fmask_r != MASK_FULL);
          state_s = ST_FILL;
        end else begin
          state_s = ST_PEND;
        end
      end
      default: begin
        state_s = ST_FILL;
      end
    endcase
  end

`ifdef SAMPLE_HOLD_EN
  // Last issued frame, one SAMPLE_W slot per channel, used to conceal gaps.
  logic [FRAME_W-1:0] hold_r;
  logic [FRAME_W-1:0] hold_src_s;

  // A frame issued in the same cycle as a transfer is already the newest one.
  assign hold_src_s   = issue_s ? rbuf_r : hold_r;
  assign xfer_frame_s = merge_frame(fbuf_r, fmask_r, hold_src_s);

  // Capture every issued frame as the concealment source.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_r <= {FRAME_W{1'b0}};
    end else if (!enable) begin
      hold_r <= {FRAME_W{1'b0}};
    end else if (issue_s) begin
      hold_r <= rbuf_r;
    end else begin
      hold_r <= hold_r;
    end
  end
`else
  assign xfer_frame_s = merge_frame(fbuf_r, fmask_r, {FRAME_W{1'b0}});
`endif

  // State register; disabling returns the machine to FILL.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_FILL;
    end else if (!enable) begin
      state_r <= ST_FILL;
    end else begin
      state_r <= state_s;
    end
  end

  // Fill buffer: write accepted samples, empty it when the frame moves to rbuf.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fbuf_r  <= {FRAME_W{1'b0}};
      fmask_r <= {NUM_CH{1'b0}};
    end else if (!enable) begin
      fbuf_r  <= {FRAME_W{1'b0}};
      fmask_r <= {NUM_CH{1'b0}};
    end else if (accept_s) begin
      fbuf_r[s.s_chan*SAMPLE_W +: SAMPLE_W] <= s.s_data;
      fmask_r                               <= fmask_upd_s;
    end else if (xfer_s) begin
      fbuf_r  <= {FRAME_W{1'b0}};
      fmask_r <= {NUM_CH{1'b0}};
    end
  end

  // Ready buffer: loaded on transfer, released on a tick unless refilled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rbuf_r  <= {FRAME_W{1'b0}};
      rbufv_r <= 1'b0;
    end else if (!enable) begin
      rbuf_r  <= {FRAME_W{1'b0}};
      rbufv_r <= 1'b0;
    end else if (xfer_s) begin
      rbuf_r  <= xfer_frame_s;
      rbufv_r <= 1'b1;
    end else if (issue_s) begin
      rbufv_r <= 1'b0;
    end
  end

  // Registered frame output and single-cycle event pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid        <= 1'b0;
      pdata        <= {FRAME_W{1'b0}};
      missIncr     <= 1'b0;
      dupIncr      <= 1'b0;
      underrunIncr <= 1'b0;
    end else if (!enable) begin
      valid        <= 1'b0;
      pdata        <= {FRAME_W{1'b0}};
      missIncr     <= 1'b0;
      dupIncr      <= 1'b0;
      underrunIncr <= 1'b0;
    end else begin
      valid        <= issue_s;
      missIncr     <= miss_s;
      dupIncr      <= dup_s;
      underrunIncr <= underrun_s;
      if (issue_s) begin
        pdata <= rbuf_r;
      end
    end
  end

endmodule

// File: tb/tb_sample_frame_pack.sv
// tb_sample_frame_pack: scenario tasks drive samples and frame ticks; expected
// frames go to a queue as frames complete and are compared on each valid pulse.
module tb_sample_frame_pack;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         enable = 1'b0;
  logic         frame_tick = 1'b0;
  logic         valid;
  logic [255:0] pdata;
  logic         missIncr;
  logic         dupIncr;
  logic         underrunIncr;

  sample_frame_pack_if sif ();

  sample_frame_pack dut (
    .clk          (clk),
    .rstn         (rstn),
    .enable       (enable),
    .s            (sif),
    .frame_tick   (frame_tick),
    .valid        (valid),
    .pdata        (pdata),
    .missIncr     (missIncr),
    .dupIncr      (dupIncr),
    .underrunIncr (underrunIncr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_miss = 0;
  int n_dup = 0;
  int n_under = 0;
  logic         tick_prev = 1'b0;
  logic [255:0] exp_q[$];
  logic [255:0] mon_exp;
  logic [255:0] cur_data = '0;
  logic [7:0]   cur_mask = '0;
  logic [255:0] hold_model = '0;
  logic [255:0] last_issued = '0;

  // Output monitor: scoreboard compare on valid, count event pulses.
  always @(negedge clk) begin
    if (rstn) begin
      if (valid) begin
        n_valid++;
        checks++;
        if (!tick_prev) begin
          errors++;
          $display("FAIL valid_without_tick got valid=1 with no frame_tick in previous cycle");
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame got pdata=%h required no frame", pdata);
        end else begin
          mon_exp = exp_q.pop_front();
          if (pdata !== mon_exp) begin
            errors++;
            $display("FAIL frame_data got %h required %h", pdata, mon_exp);
          end
          last_issued = mon_exp;
        end
      end
      if (missIncr) n_miss++;
      if (dupIncr) n_dup++;
      if (underrunIncr) n_under++;
    end
    tick_prev = frame_tick;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic clear_counts();
    n_valid = 0;
    n_miss  = 0;
    n_dup   = 0;
    n_under = 0;
  endtask

  task automatic push_frame();
    logic [255:0] e;
    for (int ch = 0; ch < 8; ch++) begin
      if (cur_mask[ch]) begin
        e[ch*32 +: 32] = cur_data[ch*32 +: 32];
      end else begin
`ifdef SAMPLE_HOLD_EN
        e[ch*32 +: 32] = hold_model[ch*32 +: 32];
`else
        e[ch*32 +: 32] = 32'h0;
`endif
      end
    end
    exp_q.push_back(e);
    hold_model = e;
    cur_data   = '0;
    cur_mask   = '0;
  endtask

  task automatic send(input logic [2:0] ch, input logic [31:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    sif.s_valid = 1'b1;
    sif.s_chan  = ch;
    sif.s_data  = d;
    sif.s_last  = last;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (sif.s_ready) ok = 1'b1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout chan=%0d got s_ready=0 required 1 within 64 cycles", ch);
    end else begin
      cur_data[ch*32 +: 32] = d;
      cur_mask[ch] = 1'b1;
      if (last || cur_mask == 8'hFF) push_frame();
    end
  endtask

  task automatic test_reset();
    sif.s_valid = 1'b0;
    sif.s_chan  = 3'd0;
    sif.s_data  = 32'h0;
    sif.s_last  = 1'b0;
    rstn   = 1'b0;
    enable = 1'b0;
    wait_cycles(3);
    checks++;
    if (sif.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b required 0", sif.s_ready); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", valid); end
    checks++;
    if (pdata !== 256'h0) begin errors++; $display("FAIL reset_pdata got %h required 0", pdata); end
    checks++;
    if ({missIncr, dupIncr, underrunIncr} !== 3'b000) begin
      errors++; $display("FAIL reset_incr got %b required 000", {missIncr, dupIncr, underrunIncr});
    end
    rstn = 1'b1;
    wait_cycles(1);
    checks++;
    if (sif.s_ready !== 1'b0) begin errors++; $display("FAIL disabled_s_ready got %b required 0", sif.s_ready); end
    enable = 1'b1;
    #1;
    checks++;
    if (sif.s_ready !== 1'b1) begin errors++; $display("FAIL enabled_s_ready got %b required 1", sif.s_ready); end
    wait_cycles(1);
  endtask

  task automatic test_full_frame();
    clear_counts();
    for (int ch = 0; ch < 8; ch++) send(3'(ch), 32'h1000_0000 + 32'(ch), 1'b0);
    checks++;
    if (sif.s_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready_drop got %b required 0", sif.s_ready); end
    wait_cycles(2);
    pulse_tick();
    wait_cycles(3);
    checks++;
    if (n_valid != 1) begin errors++; $display("FAIL full_valid_count got %0d required 1", n_valid); end
    checks++;
    if (pdata[31:0] !== 32'h1000_0000 || pdata[255:224] !== 32'h1000_0007) begin
      errors++; $display("FAIL full_slots got %h/%h required 10000000/10000007", pdata[31:0], pdata[255:224]);
    end
    checks++;
    if (n_miss + n_dup + n_under != 0) begin
      errors++; $display("FAIL full_incr got miss=%0d dup=%0d under=%0d required 0", n_miss, n_dup, n_under);
    end
  endtask

  task automatic test_short_frame();
    logic [191:0] exp_hi;
    for (int ch = 0; ch < 8; ch++) send(3'(ch), 32'h5, 1'b0);
    wait_cycles(2);
    pulse_tick();
    wait_cycles(3);
    clear_counts();
    send(3'd0, 32'hA, 1'b0);
    send(3'd1, 32'hB, 1'b1);
    wait_cycles(2);
    pulse_tick();
    wait_cycles(3);
`ifdef SAMPLE_HOLD_EN
    exp_hi = {6{32'h5}};
`else
    exp_hi = 192'h0;
`endif
    checks++;
    if (pdata[63:0] !== 64'h0000000B_0000000A) begin
      errors++; $display("FAIL short_low got %h required 0000000b0000000a", pdata[63:0]);
    end
    checks++;
    if (pdata[255:64] !== exp_hi) begin errors++; $display("FAIL short_high got %h required %h", pdata[255:64], exp_hi); end
    checks++;
    if (n_miss != 1 || n_valid != 1) begin
      errors++; $display("FAIL short_miss got miss=%0d valid=%0d required 1/1", n_miss, n_valid);
    end
  endtask

  task automatic test_first_last();
    clear_counts();
    send(3'd5, 32'hCAFE_0005, 1'b1);
    wait_cycles(2);
    pulse_tick();
    wait_cycles(3);
    checks++;
    if (n_miss != 1 || n_valid != 1) begin
      errors++; $display("FAIL first_last_miss got miss=%0d valid=%0d required 1/1", n_miss, n_valid);
    end
  endtask

  task automatic test_duplicate();
    clear_counts();
    send(3'd3, 32'h1, 1'b0);
    send(3'd3, 32'h2, 1'b0);
    for (int ch = 0; ch < 8; ch++) begin
      if (ch != 3) send(3'(ch), 32'h3300_0000 + 32'(ch), 1'b0);
    end
    wait_cycles(2);
    pulse_tick();
    wait_cycles(3);
    checks++;
    if (n_dup != 1) begin errors++; $display("FAIL dup_count got %0d required 1", n_dup); end
    checks++;
    if (pdata[127:96] !== 32'h2) begin errors++; $display("FAIL dup_slot got %h required 00000002", pdata[127:96]); end
    checks++;
    if (n_miss != 0) begin errors++; $display("FAIL dup_miss got %0d required 0", n_miss); end
  endtask

  task automatic test_back_to_back();
    clear_counts();
    for (int ch = 0; ch < 8; ch++) send(3'(ch), 32'hA000_0000 + 32'(ch), 1'b0);
    for (int ch = 0; ch < 8; ch++) send(3'(ch), 32'hB000_0000 + 32'(ch), 1'b0);
    wait_cycles(4);
    checks++;
    if (sif.s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready got %b required 0", sif.s_ready); end
    checks++;
    if (n_valid != 0) begin errors++; $display("FAIL bp_early_valid got %0d required 0", n_valid); end
    pulse_tick();
    wait_cycles(2);
    checks++;
    if (n_valid != 1 || sif.s_ready !== 1'b1) begin
      errors++; $display("FAIL bp_first_tick got valid=%0d s_ready=%b required 1/1", n_valid, sif.s_ready);
    end
    pulse_tick();
    wait_cycles(3);
    checks++;
    if (n_valid != 2 || n_under != 0 || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_second_tick got valid=%0d under=%0d left=%0d required 2/0/0", n_valid, n_under, exp_q.size());
    end
  endtask

  task automatic test_underrun();
    clear_counts();
    pulse_tick();
    wait_cycles(3);
    checks++;
    if (n_under != 1) begin errors++; $display("FAIL underrun_count got %0d required 1", n_under); end
    checks++;
    if (n_valid != 0) begin errors++; $display("FAIL underrun_valid got %0d required 0", n_valid); end
    checks++;
    if (pdata !== last_issued) begin errors++; $display("FAIL underrun_pdata got %h required %h", pdata, last_issued); end
  endtask

  task automatic test_enable_abort();
    clear_counts();
    for (int ch = 0; ch < 4; ch++) send(3'(ch), 32'hDEAD_0000 + 32'(ch), 1'b0);
    enable = 1'b0;
    sif.s_valid = 1'b1;
    sif.s_chan  = 3'd4;
    sif.s_data  = 32'hDEAD_0004;
    #1;
    checks++;
    if (sif.s_ready !== 1'b0) begin errors++; $display("FAIL abort_s_ready got %b required 0", sif.s_ready); end
    wait_cycles(3);
    sif.s_valid = 1'b0;
    checks++;
    if (pdata !== 256'h0) begin errors++; $display("FAIL abort_pdata_clear got %h required 0", pdata); end
    cur_data    = '0;
    cur_mask    = '0;
    hold_model  = '0;
    last_issued = '0;
    exp_q.delete();
    enable = 1'b1;
    wait_cycles(1);
    for (int ch = 0; ch < 8; ch++) send(3'(ch), 32'h7700_0000 + 32'(ch), 1'b0);
    wait_cycles(2);
    pulse_tick();
    wait_cycles(3);
    checks++;
    if (n_valid != 1 || n_miss != 0 || n_under != 0) begin
      errors++; $display("FAIL abort_refill got valid=%0d miss=%0d under=%0d required 1/0/0", n_valid, n_miss, n_under);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_first_last();
    test_duplicate();
    test_back_to_back();
    test_underrun();
    test_enable_abort();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d frames left required 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got simulation still running required completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/sample_frame_pack.md
Name: sample_frame_pack

Overview:
- Upstream feeder for the parallel-to-TDM serializer.
- Collects per-channel 32-bit audio samples from the network receive path over a valid/ready stream and assembles them into one 256-bit, 8-channel frame.
- Presents each assembled frame on a single-cycle valid/pdata pulse, paced by a frame-rate tick, so the serializer receives at most one frame per DAC frame period.
- Fully in the system clock domain; double-buffered (fill buffer + ready buffer).

Parameters:
- SAMPLE_W, 32, sample width in bits. Fixed for the TDM format; other values unsupported.
- NUM_CH, 8, channels per frame. Frame width = SAMPLE_W*NUM_CH = 256 (localparam).

Ports:
- clk  in  1  system clock
- rstn  in  1  reset
- enable  in  1  block enable; low acts as a synchronous clear
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample accepted when s_valid && s_ready
- s_chan  in  3  channel index of s_data
- s_data  in  32  sample
- s_last  in  1  last sample of the current frame
- frame_tick  in  1  one-cycle pulse per DAC frame period
- valid  out  1  one-cycle frame-valid pulse to the serializer
- pdata  out  256  frame; channel n occupies bits [32n+31:32n]
- missIncr  out  1  pulse: a frame was issued with unfilled channels
- dupIncr  out  1  pulse: a channel was written twice in one frame
- underrunIncr  out  1  pulse: frame_tick arrived with no ready frame

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk.
- Reset values: all outputs 0 (s_ready 0, valid 0, pdata 0, all Incr pulses 0); fbuf=0, fmask=0, rbuf=0, rbufV=0, state=FILL.
- enable=0: same values as reset, applied synchronously. s_ready=0. Samples offered while disabled are not consumed.
- State FILL:
  - s_ready = enable.
  - On accept: fbuf[s_chan slot] <= s_data and fmask[s_chan] <= 1.
  - If fmask[s_chan] was already 1: overwrite the slot and pulse dupIncr next cycle.
  - Frame completes on an accepted sample with s_last=1, or when the write makes fmask all-ones. Next state = PEND.
- State PEND:
  - s_ready=0.
  - Transfer when rbufV==0 or frame_tick==1 in this cycle:
    - rbuf <= fbuf, with unfilled slots forced to 0.
    - rbufV <= 1; fbuf <= 0; fmask <= 0; state <= FILL.
    - missIncr pulses next cycle if fmask != all-ones.
  - Otherwise remain in PEND (backpressure upstream).
- frame_tick handling:
  - If rbufV: next cycle valid=1 and pdata=rbuf; rbufV <= 0, unless a transfer occurs in the same cycle, in which case rbuf takes the new frame and rbufV stays 1.
  - If !rbufV: underrunIncr pulses next cycle; valid stays 0 (the serializer retransmits its held frame).
- pdata holds its last issued value between valid pulses.
- Latency: completing sample accepted at cycle N → PEND at N+1 → rbufV=1 at N+2 (if rbuf free) → valid one cycle after the next frame_tick.
- Maximum one valid per frame_tick. valid never asserts without a frame_tick in the previous cycle.
- s_last on the very first sample of a frame: the frame completes with 7 missing channels.
- All Incr outputs are single-cycle pulses, registered.

Optional Feature:
- SAMPLE_HOLD_EN:
  - Defined: unfilled channel slots at transfer take that channel's value from the previously issued frame (sample-and-hold concealment). A hold register per channel is kept. missIncr still pulses.
  - Undefined: unfilled slots are zero. No hold registers.

Test Plan:
- Full frame, in order: write chan 0..7 with data 32'h1000_000n, no s_last, then frame_tick → s_ready low one cycle after chan 7; after the tick, valid=1 for one cycle; pdata[31:0]=32'h1000_0000 and pdata[255:224]=32'h1000_0007; no Incr pulses.
- Short frame: write chan 0,1 (=32'hA, 32'hB) with s_last on chan 1, then frame_tick → pdata[63:0]=64'h0000000B_0000000A, remaining bits 0, missIncr=1 once. With SAMPLE_HOLD_EN and a prior frame of all 32'h5: slots 2..7 = 32'h5.
- Duplicate write: chan 3 written twice (32'h1 then 32'h2) within one frame → dupIncr one pulse; pdata[127:96]=32'h2.
- Backpressure: complete two frames with no frame_tick → second frame waits in PEND with s_ready=0; first tick issues frame 1 and transfers frame 2 in the same cycle; second tick issues frame 2; no data loss.
- Underrun: frame_tick with rbufV=0 → underrunIncr=1 for one cycle; valid stays 0 and pdata is unchanged.
- enable dropped mid-frame after chan 0..3 written → s_ready=0 and no valid; after re-enable, a full 8-channel frame issues with no residual data from the aborted frame.
